router_reg: RTL and testbench

- Datapath register stage of the 1x3 router, directly downstream of the router FSM's state-decode outputs.
- Captures the header, forwards header and payload bytes to the FIFO write bus, and holds a byte that arrives while the FIFO is full.
- Accumulates running packet parity, compares it against the received parity byte, and returns parity_done and low_pkt_valid to the FSM.
- Drives err to the top level.

---
 rtl/router_pkg.sv | 10 +
 rtl/router_reg_parity.sv | 27 ++
 rtl/router_reg.sv | 111 +++++++++++
 tb/tb_router_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants: byte width, destination field width and the reserved address.
package router_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_BITS  = 2;
   localparam logic [ADDR_BITS-1:0] ADDR_INVALID = 2'b11;

   function automatic logic addr_ok(input logic [ADDR_BITS-1:0] addr);
      return addr != ADDR_INVALID;
   endfunction
endpackage

// File: rtl/router_reg_parity.sv
// Running XOR of packet bytes with a compare against the received parity byte.
// 1-cycle update latency; no backpressure, the enables come straight from the FSM decode.
module parity_acc #(
   parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  clear,
   input  logic                  xor_en,
   input  logic [DATA_WIDTH-1:0] xor_dat,
   input  logic [DATA_WIDTH-1:0] ref_dat,
   output logic [DATA_WIDTH-1:0] acc,
   output logic                  mismatch
);

   always_ff @(posedge clock) begin
      if (!resetn)
         acc <= '0;
      else if (clear)
         acc <= '0;
      else if (xor_en)
         acc <= acc ^ xor_dat;
   end

   assign mismatch = (acc != ref_dat);

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header capture, FIFO write byte, full-hold byte and parity check.
// 1-cycle latency on every path; a byte arriving while the FIFO is full is parked and replayed in LOAD_AFTER_FULL.
module router_reg #(
   parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
   parameter int ADDR_BITS  = router_pkg::ADDR_BITS
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  lfd_state,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  rst_int_reg,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  parity_done,
   output logic                  low_pkt_valid,
   output logic                  err
);
   import router_pkg::*;

   logic [DATA_WIDTH-1:0] header_byte;
   logic [DATA_WIDTH-1:0] hold_byte;
   logic [DATA_WIDTH-1:0] pkt_parity;
   logic [DATA_WIDTH-1:0] int_parity;
   logic                  par_en;
   logic [DATA_WIDTH-1:0] par_dat;
   logic                  par_mismatch;

   always_ff @(posedge clock) begin
      if (!resetn)
         header_byte <= '0;
      else if (detect_add && pkt_valid && addr_ok(data_in[ADDR_BITS-1:0]))
         header_byte <= data_in;
   end

   // Every byte seen in ld_state goes to exactly one of dout or hold_byte.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         dout      <= '0;
         hold_byte <= '0;
      end else if (lfd_state) begin
         dout <= header_byte;
      end else if (ld_state && !fifo_full) begin
         dout <= data_in;
      end else if (ld_state && fifo_full) begin
         hold_byte <= data_in;
      end else if (laf_state) begin
         dout <= hold_byte;
      end else if (full_state) begin
         dout <= dout;
      end
   end

   // Header is folded in during lfd_state; payload only while pkt_valid, whatever fifo_full says.
   assign par_en  = lfd_state || (ld_state && pkt_valid);
   assign par_dat = lfd_state ? header_byte : data_in;

   parity_acc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .clock    (clock),
      .resetn   (resetn),
      .clear    (detect_add),
      .xor_en   (par_en),
      .xor_dat  (par_dat),
      .ref_dat  (pkt_parity),
      .acc      (int_parity),
      .mismatch (par_mismatch)
   );

   always_ff @(posedge clock) begin
      if (!resetn)
         pkt_parity <= '0;
      else if (detect_add)
         pkt_parity <= '0;
      else if (ld_state && !pkt_valid)
         pkt_parity <= data_in;
   end

   always_ff @(posedge clock) begin
      if (!resetn)
         low_pkt_valid <= 1'b0;
      else if (rst_int_reg)
         low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid)
         low_pkt_valid <= 1'b1;
   end

   // A parity byte parked by fifo_full completes only when replayed from hold_byte.
   always_ff @(posedge clock) begin
      if (!resetn)
         parity_done <= 1'b0;
      else if (detect_add)
         parity_done <= 1'b0;
      else if ((ld_state && !fifo_full && !pkt_valid) ||
               (laf_state && low_pkt_valid && !parity_done))
         parity_done <= 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!resetn)
         err <= 1'b0;
      else if (rst_int_reg)
         err <= par_mismatch;
      else if (detect_add && pkt_valid)
         err <= 1'b0;
   end

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: directed vector table, hand-written reset sequences, randomized packets.
module tb_router_reg;

   localparam int S_IDLE = 0, S_DA = 1, S_LFD = 2, S_LD = 3, S_LAF = 4, S_FULL = 5, S_RST = 6;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       fifo_full = 1'b0;
   logic       detect_add = 1'b0, lfd_state = 1'b0, ld_state = 1'b0;
   logic       laf_state = 1'b0, full_state = 1'b0, rst_int_reg = 1'b0;
   logic [7:0] dout;
   logic       parity_done, low_pkt_valid, err;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int         st;
      logic       pv;
      logic [7:0] din;
      logic       ff;
      logic [7:0] e_dout;
      logic       e_pd;
      logic       e_lpv;
      logic       e_err;
   } vec_t;

   vec_t tbl[$];

   router_reg dut (
      .clock        (clock),
      .resetn       (resetn),
      .pkt_valid    (pkt_valid),
      .data_in      (data_in),
      .fifo_full    (fifo_full),
      .detect_add   (detect_add),
      .lfd_state    (lfd_state),
      .ld_state     (ld_state),
      .laf_state    (laf_state),
      .full_state   (full_state),
      .rst_int_reg  (rst_int_reg),
      .dout         (dout),
      .parity_done  (parity_done),
      .low_pkt_valid(low_pkt_valid),
      .err          (err)
   );

   always #5 clock = ~clock;

   // Inputs change on negedge; outputs are read on the following negedge.
   task automatic apply(input int st, input logic pv, input logic [7:0] din, input logic ff);
      detect_add  = (st == S_DA);
      lfd_state   = (st == S_LFD);
      ld_state    = (st == S_LD);
      laf_state   = (st == S_LAF);
      full_state  = (st == S_FULL);
      rst_int_reg = (st == S_RST);
      pkt_valid   = pv;
      data_in     = din;
      fifo_full   = ff;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   task automatic addv(input int st, input logic pv, input logic [7:0] din, input logic ff,
                       input logic [7:0] ed, input logic epd, input logic elpv, input logic eerr);
      vec_t v;
      v.st = st; v.pv = pv; v.din = din; v.ff = ff;
      v.e_dout = ed; v.e_pd = epd; v.e_lpv = elpv; v.e_err = eerr;
      tbl.push_back(v);
   endtask

   initial begin
      logic [7:0] cur_hdr, exp_dout, hdr, b, par, exp_xor;
      logic [7:0] payload[$];
      logic       ff;
      int         len;

      // Normal packet 0D,AA,55,0F with parity FD
      addv(S_DA,  1, 8'h0D, 0, 8'h00, 0, 0, 0);
      addv(S_LFD, 1, 8'h11, 0, 8'h0D, 0, 0, 0);
      addv(S_LD,  1, 8'hAA, 0, 8'hAA, 0, 0, 0);
      addv(S_LD,  1, 8'h55, 0, 8'h55, 0, 0, 0);
      addv(S_LD,  1, 8'h0F, 0, 8'h0F, 0, 0, 0);
      addv(S_LD,  0, 8'hFD, 0, 8'hFD, 1, 1, 0);
      addv(S_RST, 0, 8'h00, 0, 8'hFD, 1, 0, 0);
      // Corrupt parity FC
      addv(S_DA,  1, 8'h0D, 0, 8'hFD, 0, 0, 0);
      addv(S_LFD, 1, 8'h22, 0, 8'h0D, 0, 0, 0);
      addv(S_LD,  1, 8'hAA, 0, 8'hAA, 0, 0, 0);
      addv(S_LD,  1, 8'h55, 0, 8'h55, 0, 0, 0);
      addv(S_LD,  1, 8'h0F, 0, 8'h0F, 0, 0, 0);
      addv(S_LD,  0, 8'hFC, 0, 8'hFC, 1, 1, 0);
      addv(S_RST, 0, 8'h00, 0, 8'hFC, 1, 0, 1);
      addv(S_IDLE,0, 8'h00, 0, 8'hFC, 1, 0, 1);
      // Full on payload byte 55
      addv(S_DA,  1, 8'h0D, 0, 8'hFC, 0, 0, 0);
      addv(S_LFD, 1, 8'h33, 0, 8'h0D, 0, 0, 0);
      addv(S_LD,  1, 8'hAA, 0, 8'hAA, 0, 0, 0);
      addv(S_LD,  1, 8'h55, 1, 8'hAA, 0, 0, 0);
      addv(S_FULL,1, 8'h99, 1, 8'hAA, 0, 0, 0);
      addv(S_LAF, 1, 8'h99, 0, 8'h55, 0, 0, 0);
      addv(S_LD,  1, 8'h0F, 0, 8'h0F, 0, 0, 0);
      addv(S_LD,  0, 8'hFD, 0, 8'hFD, 1, 1, 0);
      addv(S_RST, 0, 8'h00, 0, 8'hFD, 1, 0, 0);
      // Full on parity byte
      addv(S_DA,  1, 8'h0D, 0, 8'hFD, 0, 0, 0);
      addv(S_LFD, 1, 8'h44, 0, 8'h0D, 0, 0, 0);
      addv(S_LD,  1, 8'hAA, 0, 8'hAA, 0, 0, 0);
      addv(S_LD,  1, 8'h55, 0, 8'h55, 0, 0, 0);
      addv(S_LD,  1, 8'h0F, 0, 8'h0F, 0, 0, 0);
      addv(S_LD,  0, 8'hFD, 1, 8'h0F, 0, 1, 0);
      addv(S_FULL,0, 8'h66, 1, 8'h0F, 0, 1, 0);
      addv(S_LAF, 0, 8'h66, 0, 8'hFD, 1, 1, 0);
      addv(S_RST, 0, 8'h00, 0, 8'hFD, 1, 0, 0);
      // Invalid address 13 leaves header 0D in place
      addv(S_DA,  1, 8'h13, 0, 8'hFD, 0, 0, 0);
      addv(S_LFD, 1, 8'h13, 0, 8'h0D, 0, 0, 0);

      repeat (2) @(negedge clock);
      chk("reset_dout", dout, 8'h00);
      chk("reset_parity_done", {7'd0, parity_done}, 8'h00);
      chk("reset_low_pkt_valid", {7'd0, low_pkt_valid}, 8'h00);
      chk("reset_err", {7'd0, err}, 8'h00);
      resetn = 1'b1;

      foreach (tbl[i]) begin
         apply(tbl[i].st, tbl[i].pv, tbl[i].din, tbl[i].ff);
         chk($sformatf("vec%0d_dout", i), dout, tbl[i].e_dout);
         chk($sformatf("vec%0d_parity_done", i), {7'd0, parity_done}, {7'd0, tbl[i].e_pd});
         chk($sformatf("vec%0d_low_pkt_valid", i), {7'd0, low_pkt_valid}, {7'd0, tbl[i].e_lpv});
         chk($sformatf("vec%0d_err", i), {7'd0, err}, {7'd0, tbl[i].e_err});
      end

      // Reset mid-payload with a parity byte parked in hold_byte
      apply(S_DA, 1, 8'h0D, 0);
      apply(S_LFD, 1, 8'h77, 0);
      apply(S_LD, 1, 8'hAA, 0);
      apply(S_LD, 0, 8'h33, 1);
      chk("midrst_pre_lpv", {7'd0, low_pkt_valid}, 8'h01);
      chk("midrst_pre_dout", dout, 8'hAA);
      resetn = 1'b0;
      apply(S_LAF, 1, 8'h00, 0);
      chk("midrst_dout", dout, 8'h00);
      chk("midrst_parity_done", {7'd0, parity_done}, 8'h00);
      chk("midrst_low_pkt_valid", {7'd0, low_pkt_valid}, 8'h00);
      chk("midrst_err", {7'd0, err}, 8'h00);
      resetn = 1'b1;

      // Reset after a parity error clears err and the captured header
      apply(S_DA, 1, 8'h0D, 0);
      apply(S_LFD, 1, 8'h00, 0);
      apply(S_LD, 0, 8'h00, 0);
      apply(S_RST, 0, 8'h00, 0);
      chk("errrst_pre_err", {7'd0, err}, 8'h01);
      resetn = 1'b0;
      apply(S_IDLE, 0, 8'h00, 0);
      chk("errrst_err", {7'd0, err}, 8'h00);
      chk("errrst_parity_done", {7'd0, parity_done}, 8'h00);
      resetn = 1'b1;
      apply(S_LFD, 1, 8'h5A, 0);
      chk("errrst_header", dout, 8'h00);

      // Randomized packets against a packet-level model
      cur_hdr  = 8'h00;
      exp_dout = 8'h00;
      for (int p = 0; p < 150; p++) begin
         hdr = 8'($urandom);
         if ($urandom_range(0, 7) == 0) hdr[1:0] = 2'b11;
         if (hdr[1:0] != 2'b11) cur_hdr = hdr;
         apply(S_DA, 1, hdr, 0);
         chk($sformatf("pkt%0d_da_err", p), {7'd0, err}, 8'h00);
         chk($sformatf("pkt%0d_da_pd", p), {7'd0, parity_done}, 8'h00);
         apply(S_LFD, 1'($urandom), 8'($urandom), 0);
         exp_dout = cur_hdr;
         chk($sformatf("pkt%0d_hdr", p), dout, exp_dout);

         payload.delete();
         len = $urandom_range(1, 6);
         exp_xor = cur_hdr;
         for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            payload.push_back(b);
            exp_xor ^= b;
         end
         par = ($urandom_range(0, 1) == 0) ? exp_xor : 8'($urandom);
         payload.push_back(par);

         for (int k = 0; k <= len; k++) begin
            logic pv;
            pv = (k < len);
            ff = ($urandom_range(0, 3) == 0);
            apply(S_LD, pv, payload[k], ff);
            if (!ff) begin
               exp_dout = payload[k];
               chk($sformatf("pkt%0d_b%0d", p, k), dout, exp_dout);
            end else begin
               chk($sformatf("pkt%0d_b%0d_hold", p, k), dout, exp_dout);
            end
            if (!pv) begin
               chk($sformatf("pkt%0d_lpv", p), {7'd0, low_pkt_valid}, 8'h01);
               chk($sformatf("pkt%0d_pd_ld", p), {7'd0, parity_done}, {7'd0, !ff});
            end
            if (ff) begin
               for (int w = 0; w < int'($urandom_range(1, 2)); w++) begin
                  apply(S_FULL, 1'($urandom), 8'($urandom), 1);
                  chk($sformatf("pkt%0d_b%0d_full", p, k), dout, exp_dout);
               end
               apply(S_LAF, 1'($urandom), 8'($urandom), 0);
               exp_dout = payload[k];
               chk($sformatf("pkt%0d_b%0d_laf", p, k), dout, exp_dout);
               chk($sformatf("pkt%0d_b%0d_laf_pd", p, k), {7'd0, parity_done}, {7'd0, !pv});
            end
         end

         apply(S_RST, 1'b0, 8'($urandom), 0);
         chk($sformatf("pkt%0d_err", p), {7'd0, err}, {7'd0, (exp_xor != par)});
         chk($sformatf("pkt%0d_lpv_clr", p), {7'd0, low_pkt_valid}, 8'h00);
         chk($sformatf("pkt%0d_pd_end", p), {7'd0, parity_done}, 8'h01);
         if ($urandom_range(0, 3) == 0) apply(S_IDLE, 1'($urandom), 8'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
